// File: rtl/pts_pkg.sv
// Shared types and constants for the parallel-to-serial serializer.
// Optional parity state is enabled by defining PTS_SERIALIZER_PARITY_EN.
package pts_pkg;

  localparam logic PTS_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    PTS_IDLE  = 2'd0,
`ifdef PTS_SERIALIZER_PARITY_EN
    PTS_SHIFT = 2'd1,
    PTS_PARITY = 2'd2
`else
    PTS_SHIFT = 2'd1
`endif
  } pts_state_t;

endpackage

// File: rtl/pts_bit_timer.sv
// Bit period counter: counts 0..BIT_PERIOD-1 while enabled, strobe marks the
// last clock of each bit. Held at zero while disabled so every word starts aligned.
module pts_bit_timer #(
  parameter int BIT_PERIOD = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  output logic strobe
);

  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign strobe = enable && (count_reg == LAST_COUNT);

  always_comb begin
    count_next = count_reg;
    if (!enable || strobe) begin
      count_next = '0;
    end else begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pts_serializer.sv
// Parallel-to-serial shifter with a one-entry holding register and back-to-back
// word streaming. Define PTS_SERIALIZER_PARITY_EN to append an even-parity bit.
module pts_serializer
  import pts_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 1,
  parameter int BIT_PERIOD = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out,
  output logic                busy,
  output logic                bit_strobe,
  output logic                done
);

  localparam int BCW = $clog2(NUM_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NUM_BITS - 1);

  pts_state_t state_reg, state_next;
  logic [NUM_BITS-1:0] hold_reg, hold_next;
  logic                hold_full_reg, hold_full_next;
  logic [NUM_BITS-1:0] data_reg, data_next;
  logic [BCW-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                done_reg, done_next;
`ifdef PTS_SERIALIZER_PARITY_EN
  logic                parity_reg, parity_next;
`endif

  logic [NUM_BITS-1:0] data_shifted;
  logic                out_bit;
  logic                strobe;
  logic                word_end;
  logic                load_word;

  // Shift toward the output end, back-filling with the idle level.
  generate
    if (SHIFT_MSB != 0) begin : g_msb_first
      assign data_shifted = {data_reg[NUM_BITS-2:0], PTS_IDLE_LEVEL};
      assign out_bit      = data_reg[NUM_BITS-1];
    end else begin : g_lsb_first
      assign data_shifted = {PTS_IDLE_LEVEL, data_reg[NUM_BITS-1:1]};
      assign out_bit      = data_reg[0];
    end
  endgenerate

  pts_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .enable(state_reg != PTS_IDLE),
    .strobe(strobe)
  );

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    data_next      = data_reg;
    bit_cnt_next   = bit_cnt_reg;
    done_next      = 1'b0;
    word_end       = 1'b0;
    load_word      = 1'b0;
`ifdef PTS_SERIALIZER_PARITY_EN
    parity_next    = parity_reg;
`endif

    if (in_valid && !hold_full_reg) begin
      hold_next      = parallel_in;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      PTS_IDLE: begin
        if (hold_full_reg) load_word = 1'b1;
      end
      PTS_SHIFT: begin
        if (strobe) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef PTS_SERIALIZER_PARITY_EN
            state_next   = PTS_PARITY;
`else
            word_end     = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            data_next    = data_shifted;
          end
        end
      end
`ifdef PTS_SERIALIZER_PARITY_EN
      PTS_PARITY: begin
        if (strobe) word_end = 1'b1;
      end
`endif
      default: begin
        state_next = PTS_IDLE;
      end
    endcase

    // A pending word chains straight in at end of word, leaving no idle gap.
    if (word_end) begin
      done_next = 1'b1;
      if (hold_full_reg) begin
        load_word = 1'b1;
      end else begin
        state_next = PTS_IDLE;
        data_next  = '1;
      end
    end

    if (load_word) begin
      data_next      = hold_reg;
      hold_full_next = 1'b0;
      bit_cnt_next   = '0;
      state_next     = PTS_SHIFT;
`ifdef PTS_SERIALIZER_PARITY_EN
      parity_next    = ^hold_reg;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= PTS_IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      data_reg      <= '1;
      bit_cnt_reg   <= '0;
      done_reg      <= 1'b0;
`ifdef PTS_SERIALIZER_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      data_reg      <= data_next;
      bit_cnt_reg   <= bit_cnt_next;
      done_reg      <= done_next;
`ifdef PTS_SERIALIZER_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  always_comb begin
    serial_out = PTS_IDLE_LEVEL;
    case (state_reg)
      PTS_SHIFT:  serial_out = out_bit;
`ifdef PTS_SERIALIZER_PARITY_EN
      PTS_PARITY: serial_out = parity_reg;
`endif
      default:    serial_out = PTS_IDLE_LEVEL;
    endcase
  end

  assign in_ready   = !hold_full_reg;
  assign busy       = (state_reg != PTS_IDLE);
  assign bit_strobe = strobe;
  assign done       = done_reg;

endmodule
